dot_accum: RTL and testbench
============================

Name: dot_accum

Overview:
- Downstream consumer of the registered 8x8 unsigned multiplier product stream.
- Sums LEN consecutive 16-bit products into one unsigned, saturating dot-product result.
- Presents each result on a valid/ready output port, and back-pressures the product stream while a result is pending and not taken.
- Sits between the multiplier output register and the result sink (bus or FIFO).

Parameters:
- PROD_W, 16, width of incoming unsigned product.
- ACC_W, 24, accumulator/result width; must be >= PROD_W.
- LEN, 8, products per dot product; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous reset, active-high.
- clr  input  1  synchronous flush of the partial group.
- prod  input  PROD_W  unsigned product from the multiplier stage.
- prod_valid  input  1  prod is meaningful this cycle.
- prod_ready  output  1  block can accept prod this cycle (combinational).
- out_data  output  ACC_W  completed dot-product sum.
- out_ovf  output  1  group saturated; qualifies out_data.
- out_valid  output  1  out_data/out_ovf are valid.
- out_ready  input  1  sink accepts the result.
- grp_cnt  output  8  products accumulated in the current partial group.

Behaviour:
- Reset (rst=1 at a clk edge) sets: acc=0, grp_cnt=0, sat=0, out_valid=0, out_data=0, out_ovf=0, state=COLLECT.
  - rst overrides all other inputs.
  - A reset mid-group or while in HOLD discards everything, including an unaccepted result.
- Accept: a product is accepted when prod_valid && prod_ready.
- Output handshake: a result is taken when out_valid && out_ready.
- prod_ready = !out_valid || out_ready. It is 1 out of reset.
- State COLLECT (out_valid=0), on each accepted product:
  - sum = acc + zero-extended prod, computed at ACC_W+1 bits.
  - If sum > 2^ACC_W-1: sum = 2^ACC_W-1 and sat=1. sat is sticky for the group.
  - If grp_cnt < LEN-1: acc=sum, grp_cnt+=1.
  - If grp_cnt == LEN-1: out_data=sum, out_ovf=sat_next, out_valid=1, then acc=0, grp_cnt=0, sat=0, go to HOLD.
  - Latency: result is visible the cycle after the LAST product is accepted.
- State HOLD (out_valid=1):
  - out_data and out_ovf are held stable until taken.
  - prod_ready = out_ready.
  - On take with no group completing that cycle: out_valid=0, go to COLLECT.
  - On take while the accepted product completes the next group (only possible when LEN=1): new result loaded, out_valid stays 1. Zero-bubble throughput.
  - The partial group keeps accumulating in HOLD only when the product is accepted, which requires out_ready=1.
- clr (rst=0):
  - Sets acc=0, grp_cnt=0, sat=0 and discards the partial sum.
  - Does not affect a pending result (out_valid/out_data/out_ovf unchanged).
  - If clr coincides with an accepted product, the product becomes the first of a new group: acc=prod, grp_cnt=1. If LEN=1, the product completes a group per the rules above.
- prod_valid=0 leaves all accumulation state unchanged; gaps between products are legal.
- Arithmetic is unsigned only; no wrap-around ever occurs, only saturation.
- grp_cnt never exceeds LEN-1.

Test Plan:
- LEN=4, ACC_W=24, out_ready=1: products 100, 200, 300, 400 on consecutive cycles -> one cycle after the 400 accept, out_valid=1, out_data=1000 (0x0003E8), out_ovf=0 for exactly one cycle; grp_cnt returns 0.
- LEN=4, ACC_W=17: four products of 0xFFFF -> out_data=0x1FFFF, out_ovf=1. Next group 1, 2, 3, 4 -> out_data=10, out_ovf=0 (sat cleared).
- Backpressure, LEN=2: products 5, 7, then out_ready=0 for 5 cycles while prod_valid=1 with prod=9 -> out_data=12 held stable, prod_ready=0, 9 not accepted. Then out_ready=1 -> 9 accepted the same cycle the result is taken, grp_cnt=1.
- clr, LEN=4: products 10, 20, then clr together with accepted product 3, then 4, 5, 6 -> out_data=18. Also clr while out_valid=1 -> pending result unchanged.
- LEN=1, out_ready=1, continuous products 1, 2, 3, 4 -> out_valid stays 1 for four consecutive cycles with out_data 1, 2, 3, 4 and no bubbles. With out_ready toggling 1/0 -> each value is held until taken.
- Reset: rst=1 after two of four products, and again while out_valid=1 -> next cycle all outputs are 0, grp_cnt=0, prod_ready=1. A subsequent full group sums from zero.

Source files
------------

// File: rtl/dot_accum.sv
// dot_accum: sums LEN unsigned products into one saturating result and
// presents it on a valid/ready port, stalling the product stream while it waits.
module dot_accum #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        grp_cnt
);

    typedef enum logic {
        COLLECT,
        HOLD
    } state_t;

    localparam logic [7:0]       LAST   = 8'(LEN - 1);
    localparam logic [ACC_W-1:0] SAT_MX = {ACC_W{1'b1}};

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] data_q, data_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] acc_base;
    logic [7:0]       cnt_base;
    logic             sat_base;
    logic [ACC_W:0]   sum_w;
    logic [ACC_W-1:0] sum_sat;
    logic             sat_next;
    logic             accept;
    logic             take;
    logic             last;

    assign out_valid  = (state_q == HOLD);
    assign prod_ready = !out_valid || out_ready;
    assign accept     = prod_valid && prod_ready;
    assign take       = out_valid && out_ready;

    assign out_data = data_q;
    assign out_ovf  = ovf_q;
    assign grp_cnt  = cnt_q;

    // clr empties the partial group before a same-cycle product is added
    always_comb begin
        acc_base = acc_q;
        cnt_base = cnt_q;
        sat_base = sat_q;
        if (clr) begin
            acc_base = '0;
            cnt_base = '0;
            sat_base = 1'b0;
        end
    end

    always_comb begin
        sum_w    = {1'b0, acc_base} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
        sum_sat  = sum_w[ACC_W] ? SAT_MX : sum_w[ACC_W-1:0];
        sat_next = sat_base | sum_w[ACC_W];
        last     = (cnt_base == LAST);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_base;
        cnt_d   = cnt_base;
        sat_d   = sat_base;
        data_d  = data_q;
        ovf_d   = ovf_q;

        if (accept) begin
            if (last) begin
                acc_d = '0;
                cnt_d = '0;
                sat_d = 1'b0;
            end else begin
                acc_d = sum_sat;
                cnt_d = cnt_base + 8'd1;
                sat_d = sat_next;
            end
        end

        unique case (state_q)
            COLLECT: begin
                if (accept && last) begin
                    data_d  = sum_sat;
                    ovf_d   = sat_next;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // a completing product in HOLD implies a take: zero-bubble reload
                if (accept && last) begin
                    data_d  = sum_sat;
                    ovf_d   = sat_next;
                    state_d = HOLD;
                end else if (take) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_dot_accum.sv
// tb_dot_accum: directed table and sequence checks of dot_accum across
// several LEN/ACC_W configurations sharing one stimulus bus.
module tb_dot_accum;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [15:0] prod;
    logic        prod_valid;
    logic        out_ready;

    logic        a_prdy, a_vld, a_ovf;
    logic [23:0] a_data;
    logic [7:0]  a_cnt;
    logic        b_prdy, b_vld, b_ovf;
    logic [16:0] b_data;
    logic [7:0]  b_cnt;
    logic        c_prdy, c_vld, c_ovf;
    logic [23:0] c_data;
    logic [7:0]  c_cnt;
    logic        d_prdy, d_vld, d_ovf;
    logic [23:0] d_data;
    logic [7:0]  d_cnt;

    int checks = 0;
    int errors = 0;

    dot_accum #(.PROD_W(16), .ACC_W(24), .LEN(4)) u_len4 (
        .clk(clk), .rst(rst), .clr(clr), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(a_prdy),
        .out_data(a_data), .out_ovf(a_ovf), .out_valid(a_vld),
        .out_ready(out_ready), .grp_cnt(a_cnt)
    );

    dot_accum #(.PROD_W(16), .ACC_W(17), .LEN(4)) u_w17 (
        .clk(clk), .rst(rst), .clr(clr), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(b_prdy),
        .out_data(b_data), .out_ovf(b_ovf), .out_valid(b_vld),
        .out_ready(out_ready), .grp_cnt(b_cnt)
    );

    dot_accum #(.PROD_W(16), .ACC_W(24), .LEN(2)) u_len2 (
        .clk(clk), .rst(rst), .clr(clr), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(c_prdy),
        .out_data(c_data), .out_ovf(c_ovf), .out_valid(c_vld),
        .out_ready(out_ready), .grp_cnt(c_cnt)
    );

    dot_accum #(.PROD_W(16), .ACC_W(24), .LEN(1)) u_len1 (
        .clk(clk), .rst(rst), .clr(clr), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(d_prdy),
        .out_data(d_data), .out_ovf(d_ovf), .out_valid(d_vld),
        .out_ready(out_ready), .grp_cnt(d_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        clr;
        logic        pv;
        logic [15:0] prod;
        logic        ordy;
        logic        prdy;
        logic        vld;
        logic [23:0] data;
        logic        ovf;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic c, logic v, logic [15:0] p, logic r,
                                logic pr, logic ov, logic [23:0] d,
                                logic of, logic [7:0] n);
        vec_t t;
        t.clr = c; t.pv = v; t.prod = p; t.ordy = r;
        t.prdy = pr; t.vld = ov; t.data = d; t.ovf = of; t.cnt = n;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic c, logic v, logic [15:0] p, logic r);
        clr = c; prod_valid = v; prod = p; out_ready = r;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 1);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic feed(logic [15:0] p);
        drive(0, 1, p, 1);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 1);

        tv.push_back(mk(0, 1, 100, 1, 1, 0, 0,    0, 1));
        tv.push_back(mk(0, 1, 200, 1, 1, 0, 0,    0, 2));
        tv.push_back(mk(0, 0, 0,   1, 1, 0, 0,    0, 2));
        tv.push_back(mk(0, 1, 300, 1, 1, 0, 0,    0, 3));
        tv.push_back(mk(0, 1, 400, 1, 1, 1, 1000, 0, 0));
        tv.push_back(mk(0, 0, 0,   1, 1, 0, 0,    0, 0));
        tv.push_back(mk(0, 1, 10,  1, 1, 0, 0,    0, 1));
        tv.push_back(mk(0, 1, 20,  1, 1, 0, 0,    0, 2));
        tv.push_back(mk(1, 1, 3,   1, 1, 0, 0,    0, 1));
        tv.push_back(mk(0, 1, 4,   1, 1, 0, 0,    0, 2));
        tv.push_back(mk(0, 1, 5,   1, 1, 0, 0,    0, 3));
        tv.push_back(mk(0, 1, 6,   1, 1, 1, 18,   0, 0));
        tv.push_back(mk(1, 0, 0,   0, 0, 1, 18,   0, 0));
        tv.push_back(mk(0, 1, 50,  0, 0, 1, 18,   0, 0));
        tv.push_back(mk(0, 1, 50,  1, 1, 0, 0,    0, 1));
        tv.push_back(mk(1, 0, 0,   1, 1, 0, 0,    0, 0));

        do_reset();
        chk("rst_vld",  32'(a_vld),  0);
        chk("rst_data", 32'(a_data), 0);
        chk("rst_ovf",  32'(a_ovf),  0);
        chk("rst_cnt",  32'(a_cnt),  0);
        chk("rst_prdy", 32'(a_prdy), 1);

        // table: LEN=4, ACC_W=24
        foreach (tv[i]) begin
            drive(tv[i].clr, tv[i].pv, tv[i].prod, tv[i].ordy);
            #1;
            chk($sformatf("v%0d_prdy", i), 32'(a_prdy), 32'(tv[i].prdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_vld", i), 32'(a_vld), 32'(tv[i].vld));
            chk($sformatf("v%0d_cnt", i), 32'(a_cnt), 32'(tv[i].cnt));
            if (tv[i].vld) begin
                chk($sformatf("v%0d_data", i), 32'(a_data), 32'(tv[i].data));
                chk($sformatf("v%0d_ovf", i), 32'(a_ovf), 32'(tv[i].ovf));
            end
        end

        // saturation, ACC_W=17
        do_reset();
        for (int k = 0; k < 4; k++) feed(16'hFFFF);
        chk("sat_vld",  32'(b_vld),  1);
        chk("sat_data", 32'(b_data), 32'h1FFFF);
        chk("sat_ovf",  32'(b_ovf),  1);
        for (int k = 1; k <= 4; k++) feed(16'(k));
        chk("sat2_vld",  32'(b_vld),  1);
        chk("sat2_data", 32'(b_data), 10);
        chk("sat2_ovf",  32'(b_ovf),  0);

        // backpressure, LEN=2
        do_reset();
        feed(5);
        feed(7);
        chk("bp_vld",  32'(c_vld),  1);
        chk("bp_data", 32'(c_data), 12);
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 9, 0);
            #1;
            chk($sformatf("bp%0d_prdy", k), 32'(c_prdy), 0);
            tick();
            chk($sformatf("bp%0d_data", k), 32'(c_data), 12);
            chk($sformatf("bp%0d_vld", k), 32'(c_vld), 1);
            chk($sformatf("bp%0d_cnt", k), 32'(c_cnt), 0);
        end
        drive(0, 1, 9, 1);
        #1;
        chk("bp_rel_prdy", 32'(c_prdy), 1);
        tick();
        chk("bp_rel_vld", 32'(c_vld), 0);
        chk("bp_rel_cnt", 32'(c_cnt), 1);
        feed(1);
        chk("bp_next_data", 32'(c_data), 10);
        chk("bp_next_vld",  32'(c_vld),  1);

        // LEN=1 zero-bubble stream then toggling out_ready
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            feed(16'(k));
            chk($sformatf("l1_%0d_vld", k), 32'(d_vld), 1);
            chk($sformatf("l1_%0d_data", k), 32'(d_data), 32'(k));
        end
        begin
            int nxt = 5;
            int held = 4;
            for (int k = 0; k < 6; k++) begin
                logic r;
                r = (k % 2 == 0);
                drive(0, 1, 16'(nxt), r);
                tick();
                if (r) begin
                    held = nxt;
                    nxt++;
                end
                chk($sformatf("l1t%0d_vld", k), 32'(d_vld), 1);
                chk($sformatf("l1t%0d_data", k), 32'(d_data), 32'(held));
            end
        end
        drive(0, 0, 0, 1);
        tick();
        chk("l1_drain_vld", 32'(d_vld), 0);

        // reset mid-group and while holding, LEN=4
        do_reset();
        feed(100);
        feed(200);
        rst = 1'b1;
        drive(0, 0, 0, 1);
        tick();
        rst = 1'b0;
        chk("rm_vld",  32'(a_vld),  0);
        chk("rm_data", 32'(a_data), 0);
        chk("rm_cnt",  32'(a_cnt),  0);
        chk("rm_prdy", 32'(a_prdy), 1);
        for (int k = 1; k <= 4; k++) feed(16'(k));
        chk("rm_sum", 32'(a_data), 10);
        drive(0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rh_vld",  32'(a_vld),  0);
        chk("rh_data", 32'(a_data), 0);
        chk("rh_ovf",  32'(a_ovf),  0);
        chk("rh_cnt",  32'(a_cnt),  0);
        chk("rh_prdy", 32'(a_prdy), 1);
        for (int k = 0; k < 4; k++) feed(5);
        chk("rh_sum_vld", 32'(a_vld),  1);
        chk("rh_sum",     32'(a_data), 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
